// File: rtl/mant_norm.sv
// Two-stage post-addition normalizer: stage 1 counts leading zeros per lane,
// stage 2 left-shifts each lane to its MSB and forms the exponent adjust.
module mant_norm #(
  parameter int ADJ_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_pre,
  input  logic [67:0]          mant_pl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_pre,
  output logic [67:0]          mant_nrm,
  output logic [4*ADJ_W-1:0]   norm_adj,
  output logic [3:0]           lane_zero
);

  logic                 r_s1_valid;
  logic [67:0]          r_s1_mant;
  logic [1:0]           r_s1_pre;
  logic [3:0][6:0]      r_s1_lzc;

  logic                 r_s2_valid;
  logic [1:0]           r_s2_pre;
  logic [67:0]          r_s2_mant;
  logic [4*ADJ_W-1:0]   r_s2_adj;
  logic [3:0]           r_s2_zero;

  logic                 w_s2_load;
  logic                 w_s1_adv;
  logic                 w_s1_load;
  logic [3:0][6:0]      w_lzc;
  logic [67:0]          w_nrm;
  logic [4*ADJ_W-1:0]   w_adj;
  logic [3:0]           w_zero;

  // Lane is passed MSB-aligned at bit 67 with zeros below, so an empty lane
  // falls through to the lane width.
  function automatic logic [6:0] f_lzc(input logic [67:0] v, input logic [6:0] w);
    logic [6:0] cnt;
    logic       found;
    cnt   = w;
    found = 1'b0;
    for (int i = 67; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = 7'(67 - i);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  function automatic logic [ADJ_W-1:0] f_adj(input logic [6:0] lzc);
    return ADJ_W'(1) - ADJ_W'(lzc);
  endfunction

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_load;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_s1_load = in_valid & in_ready;

  always_comb begin
    w_lzc = '0;
    case (in_pre)
      2'b00: begin
        for (int k = 0; k < 4; k++)
          w_lzc[k] = f_lzc({mant_pl[17*k +: 17], 51'b0}, 7'd17);
      end
      2'b01: begin
        for (int k = 0; k < 2; k++)
          w_lzc[k] = f_lzc({mant_pl[34*k +: 34], 34'b0}, 7'd34);
      end
      default: w_lzc[0] = f_lzc(mant_pl, 7'd68);
    endcase
  end

  // An all-zero lane has lzc == W; the shift then clears it on its own.
  always_comb begin
    w_nrm  = '0;
    w_adj  = '0;
    w_zero = '0;
    case (r_s1_pre)
      2'b00: begin
        for (int k = 0; k < 4; k++) begin
          w_zero[k] = (r_s1_lzc[k] == 7'd17);
          w_nrm[17*k +: 17] = r_s1_mant[17*k +: 17] << r_s1_lzc[k];
          if (!w_zero[k]) w_adj[ADJ_W*k +: ADJ_W] = f_adj(r_s1_lzc[k]);
        end
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          w_zero[k] = (r_s1_lzc[k] == 7'd34);
          w_nrm[34*k +: 34] = r_s1_mant[34*k +: 34] << r_s1_lzc[k];
          if (!w_zero[k]) w_adj[ADJ_W*k +: ADJ_W] = f_adj(r_s1_lzc[k]);
        end
      end
      default: begin
        w_zero[0] = (r_s1_lzc[0] == 7'd68);
        w_nrm     = r_s1_mant << r_s1_lzc[0];
        if (!w_zero[0]) w_adj[ADJ_W-1:0] = f_adj(r_s1_lzc[0]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_pre   <= '0;
      r_s1_lzc   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_pre   <= '0;
      r_s2_mant  <= '0;
      r_s2_adj   <= '0;
      r_s2_zero  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_mant  <= mant_pl;
        r_s1_pre   <= in_pre;
        r_s1_lzc   <= w_lzc;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_pre  <= r_s1_pre;
          r_s2_mant <= w_nrm;
          r_s2_adj  <= w_adj;
          r_s2_zero <= w_zero;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_pre   = r_s2_pre;
  assign mant_nrm  = r_s2_mant;
  assign norm_adj  = r_s2_adj;
  assign lane_zero = r_s2_zero;

endmodule

// File: tb/tb_mant_norm.sv
// Scoreboard bench for mant_norm: accepted inputs are modelled arithmetically
// and queued; a monitor pops and compares on every output transfer.
module tb_mant_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_pre;
  logic [67:0] mant_pl;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_pre;
  logic [67:0] mant_nrm;
  logic [31:0] norm_adj;
  logic [3:0]  lane_zero;

  mant_norm #(.ADJ_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pre(in_pre), .mant_pl(mant_pl), .out_valid(out_valid),
    .out_ready(out_ready), .out_pre(out_pre), .mant_nrm(mant_nrm),
    .norm_adj(norm_adj), .lane_zero(lane_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pre;
    logic [67:0] mant;
    logic [31:0] adj;
    logic [3:0]  zero;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  exp_t held;
  logic have_held = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  logic done_rand;

  function automatic exp_t model(input logic [1:0] pre, input logic [67:0] m);
    exp_t        e;
    int          w, nl, lz, p;
    logic [67:0] mask, v;
    e     = '0;
    e.pre = pre;
    w     = (pre == 2'b00) ? 17 : (pre == 2'b01) ? 34 : 68;
    nl    = 68 / w;
    mask  = (w == 68) ? '1 : ((68'd1 << w) - 68'd1);
    for (int k = 0; k < nl; k++) begin
      v = (m >> (w * k)) & mask;
      if (v == 68'd0) begin
        e.zero[k] = 1'b1;
      end else begin
        p = 0;
        for (int j = 0; j < w; j++) if (v[j]) p = j;
        lz = w - 1 - p;
        e.mant = e.mant | (((v << lz) & mask) << (w * k));
        e.adj[8*k +: 8] = 8'(1 - lz);
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      have_held = 1'b0;
    end else begin
      if (have_held) begin
        chk("stall_valid", 128'(out_valid), 128'd1);
        chk("stall_data", 128'({out_pre, mant_nrm, norm_adj, lane_zero}), 128'(held));
      end
      if (out_valid && out_ready) begin
        have_held = 1'b0;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got mant %0h with empty queue", mant_nrm);
        end else begin
          e_mon = sb.pop_front();
          chk("out_mant", 128'(mant_nrm), 128'(e_mon.mant));
          chk("out_adj", 128'(norm_adj), 128'(e_mon.adj));
          chk("out_zero", 128'(lane_zero), 128'(e_mon.zero));
          chk("out_pre", 128'(out_pre), 128'(e_mon.pre));
          n_out++;
        end
      end else if (out_valid) begin
        have_held = 1'b1;
        held = {out_pre, mant_nrm, norm_adj, lane_zero};
      end else begin
        have_held = 1'b0;
      end
      if (in_valid && in_ready) sb.push_back(model(in_pre, mant_pl));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] pre, input logic [67:0] m);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_pre   = pre;
    mant_pl  = m;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_pre   = 2'($urandom);
    mant_pl  = 68'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      t++;
      @(negedge clk);
    end
    chk("drain_queue_empty", 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // Expects an empty pipeline before a mode-10 input of 68'h1 was accepted.
  task automatic lat_check(input string nm);
    @(negedge clk);
    chk({nm, "_early"}, 128'(out_valid), 128'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 128'(out_valid), 128'd1);
    chk({nm, "_mant"}, 128'(mant_nrm), 128'(68'h8_0000_0000_0000_0000));
    chk({nm, "_adj"}, 128'(norm_adj), 128'(32'h0000_00BE));
    chk({nm, "_zero"}, 128'(lane_zero), 128'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] rand_mant();
    logic [67:0] m;
    m = 68'({$urandom(), $urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0: m = m >> $urandom_range(0, 67);
      1: m = m & 68'({$urandom(), $urandom(), $urandom()}) & 68'({$urandom(), $urandom(), $urandom()});
      2: m = 68'd1 << $urandom_range(0, 67);
      default: ;
    endcase
    return m;
  endfunction

  initial begin
    logic [67:0] x;
    int          cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pre    = 2'b00;
    mant_pl   = '0;
    out_ready = 1'b1;
    done_rand = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_outputs", 128'({out_pre, mant_nrm, norm_adj, lane_zero}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(2'b10, 68'h1);
    lat_check("lat_mode10");
    send(2'b00, {17'h00300, 17'h00000, 17'h00001, 17'h10000});
    send(2'b01, {34'h0_8000_0000, 34'h0});
    send(2'b00, 68'h0);
    send(2'b01, '1);
    drain();

    x = rand_mant();
    send(2'b00, rand_mant());
    send(2'b10, x);
    send(2'b01, rand_mant());
    send(2'b11, x);
    drain();

    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(2'($urandom), rand_mant());
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", 128'(in_ready), 128'd0);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (4) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        chk("bp_burst_count", 128'(cnt), 128'd4);
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(2'($urandom), rand_mant());
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    send(2'b00, rand_mant());
    send(2'b01, rand_mant());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 128'(out_valid), 128'd0);
    chk("rst2_in_ready", 128'(in_ready), 128'd1);
    chk("rst2_outputs", 128'({out_pre, mant_nrm, norm_adj, lane_zero}), 128'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b10, 68'h1);
    lat_check("lat_after_rst");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
